// File: rtl/memory_match_ctrl.sv
// memory_match_ctrl
// Turn sequencer for the 4x4 memory card game. It reads two cards from the
// board's one-cycle read port and compares them. It then tracks the revealed
// and matched cells, keeps score and raises game_over once every cell is matched.
// Build option: define MEMORY_TWO_PLAYER_EN to let two players alternate turns.
// Without it, one player (player 0) earns every point.
module memory_match_ctrl #(
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int CARD_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel_n,
    input  logic [1:0]        cur_row,
    input  logic [1:0]        cur_col,
    output logic              rd_en,
    output logic [3:0]        rd_addr,
    input  logic [CARD_W-1:0] rd_data,
    output logic [15:0]       revealed_mask,
    output logic [15:0]       matched_mask,
    output logic              player,
    output logic [3:0]        score0,
    output logic [3:0]        score1,
    output logic              busy,
    output logic              game_over
);

    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [2:0] {
        PICK1,
        WAIT1,
        PICK2,
        WAIT2,
        CMP,
        SHOW,
        DONE
    } state_t;

    state_t             state_reg;

    // Button synchronizer, edge detector and the resulting one-cycle pulse
    logic               sync0_reg;
    logic               sync1_reg;
    logic               sync2_reg;
    logic               sel_pulse_reg;

    // Pick bookkeeping
    logic [3:0]         a1_reg;
    logic [3:0]         a2_reg;
    logic [CARD_W-1:0]  c1_reg;
    logic [CARD_W-1:0]  c2_reg;
    logic [CNT_W-1:0]   show_cnt_reg;

    // Registered outputs
    logic               rd_en_reg;
    logic [3:0]         rd_addr_reg;
    logic [15:0]        revealed_reg;
    logic [15:0]        matched_reg;
    logic               player_reg;
    logic [3:0]         score0_reg;
    logic [3:0]         score1_reg;
    logic               busy_reg;
    logic               game_over_reg;

    // Derived combinational helpers
    logic [3:0]         pick_addr;
    logic               pick_ok;
    logic [15:0]        pair_bits;
    logic               all_matched;

    assign pick_addr   = {cur_row, cur_col};
    // A cell can be picked only while it is face down and unmatched
    assign pick_ok     = sel_pulse_reg & ~revealed_reg[pick_addr] & ~matched_reg[pick_addr];
    assign pair_bits   = (16'h0001 << a1_reg) | (16'h0001 << a2_reg);
    assign all_matched = ((matched_reg | pair_bits) == 16'hFFFF);

    assign rd_en         = rd_en_reg;
    assign rd_addr       = rd_addr_reg;
    assign revealed_mask = revealed_reg;
    assign matched_mask  = matched_reg;
    assign player        = player_reg;
    assign score0        = score0_reg;
    assign score1        = score1_reg;
    assign busy          = busy_reg;
    assign game_over     = game_over_reg;

    // Synchronize the button and turn each synchronized press into a registered one-cycle pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_reg     <= 1'b1;
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            sel_pulse_reg <= 1'b0;
        end else begin
            sync0_reg     <= sel_n;
            sync1_reg     <= sync0_reg;
            sync2_reg     <= sync1_reg;
            sel_pulse_reg <= sync2_reg & ~sync1_reg;
        end
    end

    // Turn FSM with registered outputs. Pulses outside PICK1/PICK2 are simply not consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= PICK1;
            a1_reg        <= 4'd0;
            a2_reg        <= 4'd0;
            c1_reg        <= '0;
            c2_reg        <= '0;
            show_cnt_reg  <= '0;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= 4'd0;
            revealed_reg  <= 16'h0000;
            matched_reg   <= 16'h0000;
            player_reg    <= 1'b0;
            score0_reg    <= 4'd0;
            score1_reg    <= 4'd0;
            busy_reg      <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            rd_en_reg <= 1'b0;
            case (state_reg)
                PICK1: begin
                    if (pick_ok) begin
                        rd_addr_reg <= pick_addr;
                        rd_en_reg   <= 1'b1;
                        a1_reg      <= pick_addr;
                        busy_reg    <= 1'b1;
                        state_reg   <= WAIT1;
                    end
                end
                WAIT1: begin
                    c1_reg       <= rd_data;
                    revealed_reg <= revealed_reg | (16'h0001 << a1_reg);
                    busy_reg     <= 1'b0;
                    state_reg    <= PICK2;
                end
                PICK2: begin
                    // a1 is already face up here, so pick_ok rejects it
                    if (pick_ok) begin
                        rd_addr_reg <= pick_addr;
                        rd_en_reg   <= 1'b1;
                        a2_reg      <= pick_addr;
                        busy_reg    <= 1'b1;
                        state_reg   <= WAIT2;
                    end
                end
                WAIT2: begin
                    c2_reg       <= rd_data;
                    revealed_reg <= revealed_reg | (16'h0001 << a2_reg);
                    state_reg    <= CMP;
                end
                CMP: begin
                    if (c1_reg == c2_reg) begin
                        matched_reg  <= matched_reg | pair_bits;
                        revealed_reg <= revealed_reg & ~pair_bits;
`ifdef MEMORY_TWO_PLAYER_EN
                        if (player_reg) begin
                            if (score1_reg < 4'd8) begin
                                score1_reg <= score1_reg + 4'd1;
                            end
                        end else begin
                            if (score0_reg < 4'd8) begin
                                score0_reg <= score0_reg + 4'd1;
                            end
                        end
`else
                        if (score0_reg < 4'd8) begin
                            score0_reg <= score0_reg + 4'd1;
                        end
`endif
                        busy_reg <= 1'b0;
                        if (all_matched) begin
                            game_over_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= PICK1;
                        end
                    end else begin
                        // The counter runs N-1 down to 0, so SHOW lasts exactly SHOW_CYCLES cycles
                        show_cnt_reg <= CNT_W'(SHOW_CYCLES - 1);
                        state_reg    <= SHOW;
                    end
                end
                SHOW: begin
                    if (show_cnt_reg == '0) begin
                        revealed_reg <= revealed_reg & ~pair_bits;
`ifdef MEMORY_TWO_PLAYER_EN
                        player_reg   <= ~player_reg;
`endif
                        busy_reg     <= 1'b0;
                        state_reg    <= PICK1;
                    end else begin
                        show_cnt_reg <= show_cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= PICK1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_match_ctrl.sv
// Directed bench for memory_match_ctrl (SHOW_CYCLES = 4). The board model
// presents board[rd_addr] continuously. The card is therefore stable from the
// read strobe through the following cycle.
module tb_memory_match_ctrl;

    localparam int SHOW = 4;

`ifdef MEMORY_TWO_PLAYER_EN
    localparam bit TWO_P = 1'b1;
`else
    localparam bit TWO_P = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sel_n;
    logic [1:0]  cur_row;
    logic [1:0]  cur_col;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [2:0]  rd_data;
    logic [15:0] revealed_mask;
    logic [15:0] matched_mask;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        busy;
    logic        game_over;

    logic [2:0]  board [16];
    logic [15:0] last_rev5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rd_data = board[rd_addr];

    memory_match_ctrl #(
        .SHOW_CYCLES (SHOW),
        .CARD_W      (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sel_n         (sel_n),
        .cur_row       (cur_row),
        .cur_col       (cur_col),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .revealed_mask (revealed_mask),
        .matched_mask  (matched_mask),
        .player        (player),
        .score0        (score0),
        .score1        (score1),
        .busy          (busy),
        .game_over     (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge. Presses the cell for 4 cycles and watches 6 cycles.
    // The read must show up 3 edges after the first edge that sees sel_n low.
    task automatic do_pick(input string tag, input logic [3:0] a, input int exp_reads);
        int         n_rd;
        int         k_rd;
        logic [3:0] ad;
        logic [15:0] rv;
        n_rd = 0;
        k_rd = 0;
        ad   = 4'd0;
        rv   = 16'h0;
        cur_row = a[3:2];
        cur_col = a[1:0];
        sel_n   = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rd_en) begin
                n_rd++;
                if (k_rd == 0) begin
                    k_rd = k;
                    ad   = rd_addr;
                end
            end
            if (k == 5) rv = revealed_mask;
            if (k == 4) sel_n = 1'b1;
        end
        last_rev5 = rv;
        check({tag, ".reads"}, n_rd, exp_reads);
        if (exp_reads == 1) begin
            check({tag, ".lat"}, k_rd, 4);
            check({tag, ".addr"}, {28'd0, ad}, {28'd0, a});
            check({tag, ".rev"}, {31'd0, rv[a]}, 32'd1);
        end
    endtask

    logic [3:0] pair_a [6];
    logic [3:0] pair_b [6];
    logic [15:0] exp_matched;

    initial begin
        // Each value appears twice:
        // 0:{0,B} 1:{2,3} 2:{5,6} 3:{1,D} 4:{7,8} 5:{9,A} 6:{4,C} 7:{E,F}
        board[0]  = 3'd0; board[1]  = 3'd3; board[2]  = 3'd1; board[3]  = 3'd1;
        board[4]  = 3'd6; board[5]  = 3'd2; board[6]  = 3'd2; board[7]  = 3'd4;
        board[8]  = 3'd4; board[9]  = 3'd5; board[10] = 3'd5; board[11] = 3'd0;
        board[12] = 3'd6; board[13] = 3'd3; board[14] = 3'd7; board[15] = 3'd7;
        pair_a[0] = 4'h5; pair_b[0] = 4'h6;
        pair_a[1] = 4'h1; pair_b[1] = 4'hD;
        pair_a[2] = 4'h7; pair_b[2] = 4'h8;
        pair_a[3] = 4'h9; pair_b[3] = 4'hA;
        pair_a[4] = 4'h4; pair_b[4] = 4'hC;
        pair_a[5] = 4'hE; pair_b[5] = 4'hF;

        reset   = 1'b0;
        sel_n   = 1'b1;
        cur_row = 2'd0;
        cur_col = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.rd_en", rd_en, 0);
        check("rst.rd_addr", rd_addr, 0);
        check("rst.revealed", revealed_mask, 0);
        check("rst.matched", matched_mask, 0);
        check("rst.player", player, 0);
        check("rst.score0", score0, 0);
        check("rst.score1", score1, 0);
        check("rst.busy", busy, 0);
        check("rst.game_over", game_over, 0);

        // Matching pair (0,0) and (2,3), both value 0
        do_pick("p00", 4'h0, 1);
        check("p00.rev5", last_rev5, 16'h0001);
        do_pick("p23", 4'hB, 1);
        check("m1.matched", matched_mask, 16'h0801);
        check("m1.revealed", revealed_mask, 16'h0000);
        check("m1.score0", score0, 1);
        check("m1.player", player, 0);
        check("m1.busy", busy, 0);

        // Ineligible: matched cell, then the face-up first card
        do_pick("ign_matched", 4'h0, 0);
        do_pick("p01", 4'h1, 1);
        do_pick("ign_first", 4'h1, 0);
        check("ign.revealed", revealed_mask, 16'h0002);
        check("ign.busy", busy, 0);

        // Mismatch (0,1)=3 vs (1,0)=6: 0x0012 is visible for the CMP cycle plus 4 SHOW cycles
        do_pick("p10", 4'h4, 1);
        check("mm.rev_cmp", last_rev5, 16'h0012);
        check("mm.rev_s1", revealed_mask, 16'h0012);
        check("mm.busy", busy, 1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("mm.rev_s%0d", i), revealed_mask, 16'h0012);
        end
        @(negedge clk);
        check("mm.rev_after", revealed_mask, 16'h0000);
        check("mm.player", player, TWO_P ? 32'd1 : 32'd0);
        check("mm.busy_after", busy, 0);

        // Match {2,3}. With two players it goes to player 1.
        do_pick("p02", 4'h2, 1);
        do_pick("p03", 4'h3, 1);
        check("m2.matched", matched_mask, 16'h080D);
        check("m2.score0", score0, TWO_P ? 32'd1 : 32'd2);
        check("m2.score1", score1, TWO_P ? 32'd1 : 32'd0);

        // Mismatch {5,7}. The next press lands on the SHOW->PICK1 edge and must be dropped.
        do_pick("p05", 4'h5, 1);
        do_pick("p07", 4'h7, 1);
        do_pick("show_press", 4'h6, 0);
        check("mm2.revealed", revealed_mask, 16'h0000);
        check("mm2.player", player, 0);

        // Remaining six pairs
        exp_matched = 16'h080D;
        for (int i = 0; i < 6; i++) begin
            do_pick($sformatf("pa%0d", i), pair_a[i], 1);
            do_pick($sformatf("pb%0d", i), pair_b[i], 1);
            exp_matched = exp_matched | (16'h0001 << pair_a[i]) | (16'h0001 << pair_b[i]);
            check($sformatf("pair%0d.matched", i), matched_mask, exp_matched);
        end
        check("end.matched", matched_mask, 16'hFFFF);
        check("end.game_over", game_over, 1);
        check("end.busy", busy, 0);
        check("end.score0", score0, TWO_P ? 32'd7 : 32'd8);
        check("end.score1", score1, TWO_P ? 32'd1 : 32'd0);
        check("end.sum", 32'(score0) + 32'(score1), 8);
        do_pick("done_press", 4'h3, 0);
        check("done.game_over", game_over, 1);

        // Reset during the second read
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("r.game_over", game_over, 0);
        do_pick("r_p1", 4'h0, 1);
        cur_row = 2'd2;
        cur_col = 2'd3;
        sel_n   = 1'b0;
        repeat (4) @(negedge clk);
        check("r.rd_en_mid", rd_en, 1);
        #1 reset = 1'b0;
        #1;
        check("r.rd_en", rd_en, 0);
        check("r.rd_addr", rd_addr, 0);
        check("r.revealed", revealed_mask, 0);
        check("r.matched", matched_mask, 0);
        check("r.score0", score0, 0);
        check("r.busy", busy, 0);
        check("r.player", player, 0);
        sel_n = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("r.no_stray", rd_en, 0);
        do_pick("r_again", 4'hB, 1);
        check("r_again.revealed", revealed_mask, 16'h0800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
